id_stage_pipe: RTL and testbench

//  Parametrised decode stage for the ARM-subset pipeline, with its own ID/EX pipeline register.
//  - Decodes the fetched instruction and reads the register file.
//  - Detects RAW hazards against the EX/MEM (and optionally WB) stages and evaluates the condition field.
//  - Applies stall and flush handshakes, then presents registered control and operands to EX.
//  - Sits between IF (if_*) and EX (ex_*); counts stall cycles for performance monitoring.

---
 rtl/arm_pkg.sv | 89 ++++++++
 rtl/id_stage_pipe_if.sv | 45 ++++
 rtl/regfile_nr.sv | 39 +++
 rtl/id_stage_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-subset pipeline: exe commands, condition codes,
// instruction modes, data-processing opcodes and the ID/EX control bundle.
package arm_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // ARM data-processing opcode field instr[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef struct packed {
        logic [3:0] cmd;
        logic       wb_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       s;
        logic       b;
        logic       imm;
    } ctrl_t;

    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, ok;
        {n, z, c, v} = nzcv;
        ok = 1'b0;
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = ~z;
            COND_CS: ok = c;
            COND_CC: ok = ~c;
            COND_MI: ok = n;
            COND_PL: ok = ~n;
            COND_VS: ok = v;
            COND_VC: ok = ~v;
            COND_HI: ok = c & ~z;
            COND_LS: ok = ~c | z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = ~z & (n == v);
            COND_LE: ok = z | (n != v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF->ID and ID->EX handshake bundle of the decode stage.
// master = decode stage (owns the ID/EX register), slave = surrounding pipeline.
interface id_stage_pipe_if #(parameter int DATA_W = 32);

    // IF word transfers on a cycle with if_valid & id_ready; IF holds word while
    // id_ready is low. ID/EX contents are consumed on ex_valid & ex_ready and are
    // held stable while ex_valid & ~ex_ready.
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;
    logic              id_ready;

    logic              ex_ready;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [3:0]        ex_cmd;
    logic              ex_wb_en;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic              ex_s;
    logic              ex_b;
    logic              ex_imm;
    logic [DATA_W-1:0] ex_val_rn;
    logic [DATA_W-1:0] ex_val_rm;
    logic [11:0]       ex_shift_op;
    logic [23:0]       ex_simm24;
    logic [3:0]        ex_dest;
    logic [3:0]        ex_src1;
    logic [3:0]        ex_src2;

    modport master (
        input  if_valid, if_pc, if_instr, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_cmd, ex_wb_en, ex_mem_rd, ex_mem_wr,
               ex_s, ex_b, ex_imm, ex_val_rn, ex_val_rm, ex_shift_op, ex_simm24,
               ex_dest, ex_src1, ex_src2
    );

    modport slave (
        output if_valid, if_pc, if_instr, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_cmd, ex_wb_en, ex_mem_rd, ex_mem_wr,
               ex_s, ex_b, ex_imm, ex_val_rn, ex_val_rm, ex_shift_op, ex_simm24,
               ex_dest, ex_src1, ex_src2
    );

endinterface

// File: rtl/regfile_nr.sv
// NREGS x DATA_W register file, two async read ports, one write port, sync reset.
// Macro ID_WB_BYPASS_EN: reads return the write data of a same-cycle write.
module regfile_nr #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef ID_WB_BYPASS_EN
    assign rd_data1 = (wr_en && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
    assign rd_data2 = (wr_en && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
`else
    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register: decode, RF read, RAW hazard, condition check.
// Macro ID_WB_BYPASS_EN: WB->ID bypass in the RF instead of stalling on WB hits.
module id_stage_pipe
    import arm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NREGS       = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    id_stage_pipe_if.master        bus,
    input  logic                   flush,
    input  logic [3:0]             status,
    input  logic [3:0]             exe_dest,
    input  logic                   exe_wb_en,
    input  logic [3:0]             mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   wb_en,
    input  logic [3:0]             wb_dest,
    input  logic [DATA_W-1:0]      wb_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int AW = $clog2(NREGS);

    logic [31:0] instr;
    logic [1:0]  mode;
    logic [3:0]  opcode;
    logic        store;
    logic        two_src;
    logic        no_src1;
    logic [3:0]  src1;
    logic [3:0]  src2;
    ctrl_t       dec;
    logic        cond_ok;
    logic        ex_b_pending;
    logic        raw_exe;
    logic        raw_mem;
    logic        raw_wb;
    logic        hazard;
    logic        advance;

    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    logic              ex_valid_q;
    logic [31:0]       ex_pc_q;
    ctrl_t             ex_ctrl_q;
    logic [DATA_W-1:0] ex_val_rn_q;
    logic [DATA_W-1:0] ex_val_rm_q;
    logic [11:0]       ex_shift_op_q;
    logic [23:0]       ex_simm24_q;
    logic [3:0]        ex_dest_q;
    logic [3:0]        ex_src1_q;
    logic [3:0]        ex_src2_q;

    assign instr   = bus.if_instr;
    assign mode    = instr[27:26];
    assign opcode  = instr[24:21];
    assign store   = (mode == MODE_MEM) & ~instr[20];
    assign src1    = instr[19:16];
    assign src2    = store ? instr[15:12] : instr[3:0];
    assign two_src = ~instr[25] | store;
    // MOV/MVN ignore Rn and B has no register source in the Rn field
    assign no_src1 = (mode == MODE_BR) |
                     ((mode == MODE_DP) & ((opcode == OP_MOV) | (opcode == OP_MVN)));

    always_comb begin
        dec = '0;
        case (mode)
            MODE_DP: begin
                dec.s     = instr[20];
                dec.imm   = instr[25];
                dec.wb_en = 1'b1;
                case (opcode)
                    OP_MOV:  dec.cmd = EXE_MOV;
                    OP_MVN:  dec.cmd = EXE_MVN;
                    OP_ADD:  dec.cmd = EXE_ADD;
                    OP_ADC:  dec.cmd = EXE_ADC;
                    OP_SUB:  dec.cmd = EXE_SUB;
                    OP_SBC:  dec.cmd = EXE_SBC;
                    OP_AND:  dec.cmd = EXE_AND;
                    OP_ORR:  dec.cmd = EXE_ORR;
                    OP_EOR:  dec.cmd = EXE_EOR;
                    OP_CMP: begin
                        dec.cmd   = EXE_CMP;
                        dec.wb_en = 1'b0;
                    end
                    OP_TST: begin
                        dec.cmd   = EXE_TST;
                        dec.wb_en = 1'b0;
                    end
                    default: begin
                        dec.cmd   = EXE_NOP;
                        dec.wb_en = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                dec.cmd    = instr[20] ? EXE_LDR : EXE_STR;
                dec.imm    = instr[25];
                dec.mem_rd = instr[20];
                dec.mem_wr = ~instr[20];
                dec.wb_en  = instr[20];
            end
            MODE_BR: begin
                dec.b   = 1'b1;
                dec.imm = instr[25];
            end
            default: dec = '0;
        endcase
    end

    function automatic logic hit(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                                 input logic ns1, input logic ts);
        return ((d == s1) & ~ns1) | (ts & (d == s2));
    endfunction

    assign raw_exe = exe_wb_en & hit(exe_dest, src1, src2, no_src1, two_src);
    assign raw_mem = mem_wb_en & hit(mem_dest, src1, src2, no_src1, two_src);
`ifdef ID_WB_BYPASS_EN
    assign raw_wb  = 1'b0;
`else
    assign raw_wb  = wb_en & hit(wb_dest, src1, src2, no_src1, two_src);
`endif

    // A branch sitting in EX will flush this word anyway, so don't stall on it
    assign ex_b_pending = ex_valid_q & ex_ctrl_q.b;
    assign hazard       = bus.if_valid & ~ex_b_pending & (raw_exe | raw_mem | raw_wb);
    assign cond_ok      = cond_check(instr[31:28], status);
    assign advance      = ~ex_valid_q | bus.ex_ready;
    assign bus.id_ready = advance & ~hazard;

    regfile_nr #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (src1[AW-1:0]),
        .rd_addr2 (src2[AW-1:0]),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wb_en),
        .wr_addr  (wb_dest[AW-1:0]),
        .wr_data  (wb_data)
    );

    always_ff @(posedge clk) begin
        if (rst || flush || (advance && !(bus.if_valid && !hazard && cond_ok))) begin
            // Bubble: reset, flush, hazard, failed condition or no incoming word
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_ctrl_q     <= '0;
            ex_val_rn_q   <= '0;
            ex_val_rm_q   <= '0;
            ex_shift_op_q <= '0;
            ex_simm24_q   <= '0;
            ex_dest_q     <= '0;
            ex_src1_q     <= '0;
            ex_src2_q     <= '0;
        end else if (advance) begin
            ex_valid_q    <= 1'b1;
            ex_pc_q       <= bus.if_pc;
            ex_ctrl_q     <= dec;
            ex_val_rn_q   <= rd_data1;
            ex_val_rm_q   <= rd_data2;
            ex_shift_op_q <= instr[11:0];
            ex_simm24_q   <= instr[23:0];
            ex_dest_q     <= instr[15:12];
            ex_src1_q     <= src1;
            ex_src2_q     <= src2;
        end

        if (rst) begin
            stall_cnt <= '0;
        end else if (!flush && advance && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_cmd      = ex_ctrl_q.cmd;
    assign bus.ex_wb_en    = ex_ctrl_q.wb_en;
    assign bus.ex_mem_rd   = ex_ctrl_q.mem_rd;
    assign bus.ex_mem_wr   = ex_ctrl_q.mem_wr;
    assign bus.ex_s        = ex_ctrl_q.s;
    assign bus.ex_b        = ex_ctrl_q.b;
    assign bus.ex_imm      = ex_ctrl_q.imm;
    assign bus.ex_val_rn   = ex_val_rn_q;
    assign bus.ex_val_rm   = ex_val_rm_q;
    assign bus.ex_shift_op = ex_shift_op_q;
    assign bus.ex_simm24   = ex_simm24_q;
    assign bus.ex_dest     = ex_dest_q;
    assign bus.ex_src1     = ex_src1_q;
    assign bus.ex_src2     = ex_src2_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; follows ID_WB_BYPASS_EN for
// the WB-distance dependency case.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  status;
    logic [3:0]  exe_dest;
    logic        exe_wb_en;
    logic [3:0]  mem_dest;
    logic        mem_wb_en;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;

    localparam logic [31:0] I_ADD   = 32'hE082_1003;  // ADD R1,R2,R3
    localparam logic [31:0] I_SUB   = 32'hE042_4003;  // SUB R4,R2,R3
    localparam logic [31:0] I_MOV   = 32'hE1A0_1003;  // MOV R1,R3
    localparam logic [31:0] I_CMP   = 32'hE152_0003;  // CMP R2,R3
    localparam logic [31:0] I_ADDEQ = 32'h0082_1003;  // ADDEQ R1,R2,R3
    localparam logic [31:0] I_ADDNV = 32'hF082_1003;  // never-executed ADD
    localparam logic [31:0] I_STR   = 32'hE582_3000;  // STR R3,[R2]
    localparam logic [31:0] I_LDR   = 32'hE592_1000;  // LDR R1,[R2]
    localparam logic [31:0] I_B     = 32'hEA00_0010;  // B +0x10

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(32)) bus();

    id_stage_pipe #(
        .DATA_W      (32),
        .NREGS       (16),
        .STALL_CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush     (flush),
        .status    (status),
        .exe_dest  (exe_dest),
        .exe_wb_en (exe_wb_en),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_en     (wb_en),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .stall_cnt (stall_cnt)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] ins);
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        bus.if_instr = ins;
    endtask

    task automatic rf_write(input logic [3:0] d, input logic [31:0] v);
        wb_en   = 1'b1;
        wb_dest = d;
        wb_data = v;
        tick();
        wb_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; status = 4'b0000;
        exe_dest = 4'd0; exe_wb_en = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b0;
        wb_en = 1'b0; wb_dest = 4'd0; wb_data = 32'd0;
        bus.if_valid = 1'b0; bus.if_pc = 32'd0; bus.if_instr = 32'd0; bus.ex_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_val("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk_val("rst_ex_cmd", 32'(bus.ex_cmd), 32'd0);
        chk_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk_val("rst_id_ready", 32'(bus.id_ready), 32'd1);

        // Read every register pair through ADD R0,R(2k),R(2k+1)
        for (int k = 0; k < 8; k++) begin
            present(32'h10 + 32'(4 * k), 32'hE080_0000 | (32'(2 * k) << 16) | 32'(2 * k + 1));
            tick();
            chk_val($sformatf("rf_zero_valid_%0d", k), 32'(bus.ex_valid), 32'd1);
            chk_val($sformatf("rf_zero_r%0d", 2 * k), bus.ex_val_rn, 32'd0);
            chk_val($sformatf("rf_zero_r%0d", 2 * k + 1), bus.ex_val_rm, 32'd0);
        end
        bus.if_valid = 1'b0;
        rf_write(4'd2, 32'd5);
        rf_write(4'd3, 32'd7);

        // Plain ADD
        present(32'h100, I_ADD);
        #1;
        chk_val("add_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        chk_val("add_valid", 32'(bus.ex_valid), 32'd1);
        chk_val("add_pc", bus.ex_pc, 32'h100);
        chk_val("add_cmd", 32'(bus.ex_cmd), 32'b0010);
        chk_val("add_rn", bus.ex_val_rn, 32'd5);
        chk_val("add_rm", bus.ex_val_rm, 32'd7);
        chk_val("add_dest", 32'(bus.ex_dest), 32'd1);
        chk_val("add_wb_en", 32'(bus.ex_wb_en), 32'd1);
        chk_val("add_src1", 32'(bus.ex_src1), 32'd2);
        chk_val("add_src2", 32'(bus.ex_src2), 32'd3);
        chk_val("add_shift_op", 32'(bus.ex_shift_op), 32'h003);

        // EX-stage hazard on Rn
        present(32'h104, I_ADD);
        exe_dest = 4'd2; exe_wb_en = 1'b1;
        #1;
        chk_val("haz_exe_id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        exp_stall++;
        chk_val("haz_exe_bubble", 32'(bus.ex_valid), 32'd0);
        chk_val("haz_exe_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        exe_wb_en = 1'b0;
        #1;
        chk_val("haz_exe_release", 32'(bus.id_ready), 32'd1);
        tick();
        chk_val("haz_exe_issue", 32'(bus.ex_valid), 32'd1);
        chk_val("haz_exe_rn", bus.ex_val_rn, 32'd5);

        // MEM-stage hazard on Rm
        mem_dest = 4'd3; mem_wb_en = 1'b1;
        #1;
        chk_val("haz_mem_id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        exp_stall++;
        chk_val("haz_mem_bubble", 32'(bus.ex_valid), 32'd0);
        chk_val("haz_mem_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        mem_wb_en = 1'b0;

        // MOV ignores the Rn field, so exe_dest = 0 must not stall it
        present(32'h108, I_MOV);
        exe_dest = 4'd0; exe_wb_en = 1'b1;
        #1;
        chk_val("mov_no_haz", 32'(bus.id_ready), 32'd1);
        tick();
        chk_val("mov_cmd", 32'(bus.ex_cmd), 32'b0001);
        chk_val("mov_rm", bus.ex_val_rm, 32'd7);
        exe_wb_en = 1'b0;

        present(32'h10C, I_CMP);
        tick();
        chk_val("cmp_cmd", 32'(bus.ex_cmd), 32'b0100);
        chk_val("cmp_wb_en", 32'(bus.ex_wb_en), 32'd0);
        chk_val("cmp_s", 32'(bus.ex_s), 32'd1);

        present(32'h110, I_STR);
        tick();
        chk_val("str_mem_wr", 32'(bus.ex_mem_wr), 32'd1);
        chk_val("str_wb_en", 32'(bus.ex_wb_en), 32'd0);
        chk_val("str_rd_val", bus.ex_val_rm, 32'd7);
        chk_val("str_src2", 32'(bus.ex_src2), 32'd3);

        present(32'h114, I_LDR);
        tick();
        chk_val("ldr_mem_rd", 32'(bus.ex_mem_rd), 32'd1);
        chk_val("ldr_wb_en", 32'(bus.ex_wb_en), 32'd1);
        chk_val("ldr_cmd", 32'(bus.ex_cmd), 32'b0010);

        // Condition field
        status = 4'b0000;
        present(32'h118, I_ADDEQ);
        tick();
        chk_val("eq_z0_valid", 32'(bus.ex_valid), 32'd0);
        chk_val("eq_z0_wb_en", 32'(bus.ex_wb_en), 32'd0);
        status = 4'b0100;
        tick();
        chk_val("eq_z1_valid", 32'(bus.ex_valid), 32'd1);
        chk_val("eq_z1_cmd", 32'(bus.ex_cmd), 32'b0010);
        present(32'h11C, I_ADDNV);
        tick();
        chk_val("nv_valid", 32'(bus.ex_valid), 32'd0);

        // Back-pressure hold, then flush during the hold
        present(32'h200, I_ADD);
        tick();
        chk_val("hold_load", 32'(bus.ex_valid), 32'd1);
        bus.ex_ready = 1'b0;
        present(32'h204, I_SUB);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_val($sformatf("hold_id_ready_%0d", i), 32'(bus.id_ready), 32'd0);
            tick();
            chk_val($sformatf("hold_valid_%0d", i), 32'(bus.ex_valid), 32'd1);
            chk_val($sformatf("hold_pc_%0d", i), bus.ex_pc, 32'h200);
            chk_val($sformatf("hold_dest_%0d", i), 32'(bus.ex_dest), 32'd1);
        end
        chk_val("hold_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        flush = 1'b1;
        tick();
        chk_val("hold_flush", 32'(bus.ex_valid), 32'd0);
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        tick();
        chk_val("sub_valid", 32'(bus.ex_valid), 32'd1);
        chk_val("sub_cmd", 32'(bus.ex_cmd), 32'b0100);
        chk_val("sub_dest", 32'(bus.ex_dest), 32'd4);
        chk_val("sub_pc", bus.ex_pc, 32'h204);

        // Flush beats a simultaneous hazard; no stall counted
        present(32'h208, I_ADD);
        exe_dest = 4'd2; exe_wb_en = 1'b1; flush = 1'b1;
        tick();
        chk_val("flush_haz_valid", 32'(bus.ex_valid), 32'd0);
        chk_val("flush_haz_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        flush = 1'b0; exe_wb_en = 1'b0;

        // Branch in EX suppresses hazard stalls for the following word
        present(32'h300, I_B);
        tick();
        chk_val("b_flag", 32'(bus.ex_b), 32'd1);
        chk_val("b_simm24", 32'(bus.ex_simm24), 32'h10);
        chk_val("b_wb_en", 32'(bus.ex_wb_en), 32'd0);
        present(32'h304, I_ADD);
        exe_dest = 4'd2; exe_wb_en = 1'b1;
        #1;
        chk_val("b_pending_no_haz", 32'(bus.id_ready), 32'd1);
        tick();
        chk_val("b_pending_issue", 32'(bus.ex_valid), 32'd1);
        chk_val("b_pending_pc", bus.ex_pc, 32'h304);
        chk_val("after_b_haz", 32'(bus.id_ready), 32'd0);
        exe_wb_en = 1'b0;
        bus.if_valid = 1'b0;
        tick();

        // Writeback of R2 in the same cycle the ADD reads it
        present(32'h400, I_ADD);
        wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'd9;
        #1;
`ifdef ID_WB_BYPASS_EN
        chk_val("wb_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        wb_en = 1'b0;
`else
        chk_val("wb_id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        exp_stall++;
        wb_en = 1'b0;
        chk_val("wb_bubble", 32'(bus.ex_valid), 32'd0);
        #1;
        chk_val("wb_release", 32'(bus.id_ready), 32'd1);
        tick();
`endif
        chk_val("wb_valid", 32'(bus.ex_valid), 32'd1);
        chk_val("wb_rn", bus.ex_val_rn, 32'd9);
        chk_val("wb_rm", bus.ex_val_rm, 32'd7);
        chk_val("wb_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        bus.if_valid = 1'b0;
        tick();
        chk_val("idle_valid", 32'(bus.ex_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
